goertzel_power: RTL and testbench
=================================

# goertzel_power

Per-tone block-power stage directly downstream of the Goertzel filter. Accepts the filter's state pair (s0, s1) on every filter output strobe and counts BLOCK_LEN strobes. After the last strobe of a block it computes the tone power s0² + s1² − coeff·s0·s1 with one time-shared multiplier, presents the result, and pulses a clear back to the filter so the next block starts from zero state.

## Interface
- COEFF, 32'sd27969: signed Goertzel coefficient 2cos(ω)·2^COEFF_BITS, identical to the filter's value.
- COEFF_BITS, 14: fractional bits of COEFF.
- BLOCK_LEN, 256: samples per block, ≥1.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous abort: discard the partial block and any in-flight computation.
- valid_i  in  1  one-cycle strobe; s0_i/s1_i valid (filter valid_o).
- s0_i  in  32  signed filter state s0.
- s1_i  in  32  signed filter state s1.
- filt_clr_o  out  1  one-cycle pulse to the filter clr input.
- busy_o  out  1  high while computing.
- valid_o  out  1  one-cycle strobe; power_o is new.
- power_o  out  64  unsigned block power, saturated.

## Operation
- States: IDLE, SQ0, SQ1, CROSS, SCALE, DONE.
- IDLE: each valid_i increments cnt (0..BLOCK_LEN−1). On valid_i with cnt==BLOCK_LEN−1, latch s0_i/s1_i, set cnt to 0 and go to SQ0. Otherwise stay in IDLE.
- SQ0: acc ← s0·s0. filt_clr_o=1 in this cycle only.
- SQ1: acc ← acc + s1·s1.
- CROSS: prod ← s0·s1, 64-bit signed.
- SCALE: acc ← acc − ((prod·COEFF) >>> COEFF_BITS). The shift is arithmetic (floor), the product is 96-bit signed, and acc is 66-bit signed.
- DONE: power_o ← 0 if acc<0; 2^64−1 if acc≥2^64; else acc[63:0]. valid_o=1 for this cycle only, then return to IDLE.
- busy_o=1 in SQ0..DONE.
- valid_i is ignored while busy_o=1; no sample is counted.
- clr:
  - Returns to IDLE and zeroes cnt, acc and prod.
  - Forces valid_o=0 and filt_clr_o=0.
  - Leaves power_o unchanged.
  - Wins over a simultaneous valid_i, which is not counted.
- rst: same as clr, and also sets power_o=0.
- power_o holds its value until the next DONE.

## Timing
- Reset values: filt_clr_o=0, busy_o=0, valid_o=0, power_o=0, state IDLE, cnt=0.
- The final strobe of a block is accepted at edge t.
- filt_clr_o=1 during cycle t+1, so the filter sees clr at edge t+2.
- valid_o=1 and power_o are updated during cycle t+5; state is back in IDLE at t+6.
- A valid_i at cycle t+6 counts as sample 1 of the next block.
- BLOCK_LEN=1: every strobe accepted in IDLE triggers a computation.
- One multiplier (32×32 signed) serves SQ0/SQ1/CROSS. SCALE uses a 64×32 multiply and may be registered internally, but the external latency stays exactly 5 cycles.

## Structure
- Package goertzel_pkg:
  - State enum type goertzel_pwr_state_t.
  - POWER_W=64, STATE_W=32, ACC_W=66.
  - Shared with GoertzelFilter for the s0/s1 width.
- No sub-module. The shared multiplier, its operand mux and the saturator are inline.
- cnt width is $clog2(BLOCK_LEN) (min 1).

## Test plan
- COEFF=16384 (1.0), COEFF_BITS=14, BLOCK_LEN=4; four strobes, last with s0=3, s1=4 → power_o=13 with valid_o exactly 5 cycles after the 4th strobe, filt_clr_o exactly 1 cycle after it.
- COEFF=32768 (2.0), BLOCK_LEN=1, s0=−5, s1=2 → power_o=49.
- COEFF=49152 (3.0), s0=s1=1 → raw −1, power_o=0 (clamp).
- COEFF=0, s0=s1=2^31−1 → power_o=0x7FFF_FFFE_0000_0002. Repeat with s0=s1=−2^31 → power_o=2^63.
- BLOCK_LEN=4, 2 strobes, then clr simultaneous with a 3rd strobe, then 4 strobes → exactly one valid_o, after the 4th post-clr strobe.
- Strobes asserted every cycle during busy_o → ignored: next valid_o comes only after BLOCK_LEN further strobes received in IDLE. rst asserted in SCALE → no valid_o, power_o=0 the next cycle.

Source files
------------

// File: rtl/goertzel_power_pkg.sv
// Shared widths, FSM state type and the output saturator for the Goertzel power stage.
package goertzel_pkg;

  localparam int unsigned POWER_W = 64;
  localparam int unsigned STATE_W = 32;
  localparam int unsigned ACC_W   = 66;
  localparam int unsigned PROD_W  = 2 * STATE_W;
  localparam int unsigned SCALE_W = PROD_W + STATE_W;

  typedef enum logic [2:0] {
    StIdle,
    StSq0,
    StSq1,
    StCross,
    StScale,
    StDone
  } goertzel_pwr_state_t;

  // Clamp the signed accumulator into the unsigned power range.
  function automatic logic [POWER_W-1:0] sat_power(input logic signed [ACC_W-1:0] acc);
    if (acc[ACC_W-1]) begin
      return '0;
    end else if (|acc[ACC_W-2:POWER_W]) begin
      return '1;
    end
    return acc[POWER_W-1:0];
  endfunction

endpackage

// File: rtl/goertzel_power_if.sv
// Sample/result bundle between the Goertzel filter side and the power stage.
interface goertzel_power_if;

  logic                                     clr;
  logic                                     valid_i;
  logic signed [goertzel_pkg::STATE_W-1:0]  s0_i;
  logic signed [goertzel_pkg::STATE_W-1:0]  s1_i;
  logic                                     filt_clr_o;
  logic                                     busy_o;
  logic                                     valid_o;
  logic        [goertzel_pkg::POWER_W-1:0]  power_o;

  modport slave (
    input  clr, valid_i, s0_i, s1_i,
    output filt_clr_o, busy_o, valid_o, power_o
  );

  modport master (
    output clr, valid_i, s0_i, s1_i,
    input  filt_clr_o, busy_o, valid_o, power_o
  );

endinterface

// File: rtl/goertzel_power.sv
// Block power stage: counts filter strobes, then computes s0^2 + s1^2 - coeff*s0*s1
// over five cycles with one shared 32x32 multiplier and saturates the result.
module goertzel_power
  import goertzel_pkg::*;
#(
  parameter logic signed [31:0] COEFF      = 32'sd27969,
  parameter int unsigned        COEFF_BITS = 14,
  parameter int unsigned        BLOCK_LEN  = 256
) (
  input  logic             clk,
  input  logic             rst,
  goertzel_power_if.slave  bus
);

  localparam int unsigned     CntW    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BLOCK_LEN - 1);

  goertzel_pwr_state_t        state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic signed [STATE_W-1:0]  s0_q, s0_d;
  logic signed [STATE_W-1:0]  s1_q, s1_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic [POWER_W-1:0]         power_q, power_d;

  logic signed [STATE_W-1:0]  mul_a, mul_b;
  logic signed [PROD_W-1:0]   mul_p;
  logic signed [SCALE_W-1:0]  scale_full;
  logic signed [SCALE_W-1:0]  scaled;
  logic signed [ACC_W-1:0]    acc_scaled;
  logic                       unused_scaled;

  // Operand mux for the single multiplier shared by SQ0, SQ1 and CROSS.
  always_comb begin
    mul_a = s0_q;
    mul_b = s0_q;
    case (state_q)
      StSq1: begin
        mul_a = s1_q;
        mul_b = s1_q;
      end
      StCross: begin
        mul_a = s0_q;
        mul_b = s1_q;
      end
      default: ;
    endcase
  end

  assign mul_p      = PROD_W'(mul_a) * PROD_W'(mul_b);
  // Cross term scaling: arithmetic shift gives floor rounding of the fixed-point product.
  assign scale_full = SCALE_W'(prod_q) * SCALE_W'(COEFF);
  assign scaled     = scale_full >>> COEFF_BITS;
  assign acc_scaled = acc_q - scaled[ACC_W-1:0];
  assign unused_scaled = ^scaled[SCALE_W-1:ACC_W];

  // Next-state and datapath sequencing; clr overrides everything except power_o.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    power_d = power_q;
    case (state_q)
      StIdle: begin
        if (bus.valid_i) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            s0_d    = bus.s0_i;
            s1_d    = bus.s1_i;
            state_d = StSq0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StSq0: begin
        acc_d   = ACC_W'(mul_p);
        state_d = StSq1;
      end
      StSq1: begin
        acc_d   = acc_q + ACC_W'(mul_p);
        state_d = StCross;
      end
      StCross: begin
        prod_d  = mul_p;
        state_d = StScale;
      end
      StScale: begin
        // Result lands at the edge into DONE so it is visible alongside valid_o.
        acc_d   = acc_scaled;
        power_d = sat_power(acc_scaled);
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (bus.clr) begin
      state_d = StIdle;
      cnt_d   = '0;
      acc_d   = '0;
      prod_d  = '0;
      power_d = power_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      power_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      power_q <= power_d;
    end
  end

  assign bus.filt_clr_o = (state_q == StSq0) && !bus.clr && !rst;
  assign bus.valid_o    = (state_q == StDone) && !bus.clr && !rst;
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.power_o    = power_q;

endmodule

// File: tb/tb_goertzel_power.sv
// Self-checking bench for goertzel_power: four instances with different coefficients,
// expected powers queued at stimulus time and checked when valid_o fires.
module tb_goertzel_power;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  goertzel_power_if ifa ();
  goertzel_power_if ifb ();
  goertzel_power_if ifc ();
  goertzel_power_if ifd ();

  goertzel_power #(.COEFF(32'sd16384), .COEFF_BITS(14), .BLOCK_LEN(4)) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  goertzel_power #(.COEFF(32'sd32768), .COEFF_BITS(14), .BLOCK_LEN(1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );
  goertzel_power #(.COEFF(32'sd49152), .COEFF_BITS(14), .BLOCK_LEN(1)) u_c (
    .clk(clk), .rst(rst), .bus(ifc)
  );
  goertzel_power #(.COEFF(32'sd0), .COEFF_BITS(14), .BLOCK_LEN(1)) u_d (
    .clk(clk), .rst(rst), .bus(ifd)
  );

  int total = 0;
  int bad   = 0;
  int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0, vcnt_d = 0;
  logic [63:0] q_a[$], q_b[$], q_c[$], q_d[$];
  logic [63:0] e_a, e_b, e_c, e_d;

  localparam logic signed [31:0] SMax = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SMin = 32'sh8000_0000;

  // Reference power in wide arithmetic, then clamped to the unsigned 64-bit range.
  function automatic logic [63:0] model(input logic signed [31:0] s0, input logic signed [31:0] s1,
                                        input logic signed [31:0] c);
    logic signed [127:0] x0, x1, cx, a;
    x0 = s0;
    x1 = s1;
    cx = c;
    a  = x0 * x0 + x1 * x1 - ((x0 * x1 * cx) >>> 14);
    if (a < 0) return 64'd0;
    if (a > 128'sh0_FFFF_FFFF_FFFF_FFFF) return '1;
    return a[63:0];
  endfunction

  function automatic logic signed [31:0] rnd();
    int v;
    v = int'($urandom_range(0, 2000000)) - 1000000;
    return v;
  endfunction

  // Scoreboard: every valid_o pops the oldest expected power for that instance.
  always @(negedge clk) begin
    if (ifa.valid_o) begin
      vcnt_a++;
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL mon_a unexpected valid_o power=0x%h", ifa.power_o);
      end else begin
        e_a = q_a.pop_front();
        if (ifa.power_o !== e_a) begin
          bad++;
          $display("FAIL mon_a power got=0x%h want=0x%h", ifa.power_o, e_a);
        end
      end
    end
    if (ifb.valid_o) begin
      vcnt_b++;
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL mon_b unexpected valid_o power=0x%h", ifb.power_o);
      end else begin
        e_b = q_b.pop_front();
        if (ifb.power_o !== e_b) begin
          bad++;
          $display("FAIL mon_b power got=0x%h want=0x%h", ifb.power_o, e_b);
        end
      end
    end
    if (ifc.valid_o) begin
      vcnt_c++;
      total++;
      if (q_c.size() == 0) begin
        bad++;
        $display("FAIL mon_c unexpected valid_o power=0x%h", ifc.power_o);
      end else begin
        e_c = q_c.pop_front();
        if (ifc.power_o !== e_c) begin
          bad++;
          $display("FAIL mon_c power got=0x%h want=0x%h", ifc.power_o, e_c);
        end
      end
    end
    if (ifd.valid_o) begin
      vcnt_d++;
      total++;
      if (q_d.size() == 0) begin
        bad++;
        $display("FAIL mon_d unexpected valid_o power=0x%h", ifd.power_o);
      end else begin
        e_d = q_d.pop_front();
        if (ifd.power_o !== e_d) begin
          bad++;
          $display("FAIL mon_d power got=0x%h want=0x%h", ifd.power_o, e_d);
        end
      end
    end
  end

  // Called at a negedge; the strobe is sampled at the following posedge.
  task automatic strobe_a(input logic signed [31:0] s0, input logic signed [31:0] s1);
    ifa.valid_i = 1'b1;
    ifa.s0_i    = s0;
    ifa.s1_i    = s1;
    @(negedge clk);
    ifa.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.clr = 0; ifa.valid_i = 0; ifa.s0_i = 0; ifa.s1_i = 0;
    ifb.clr = 0; ifb.valid_i = 0; ifb.s0_i = 0; ifb.s1_i = 0;
    ifc.clr = 0; ifc.valid_i = 0; ifc.s0_i = 0; ifc.s1_i = 0;
    ifd.clr = 0; ifd.valid_i = 0; ifd.s0_i = 0; ifd.s1_i = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if (ifa.filt_clr_o !== 1'b0) begin
      bad++; $display("FAIL reset_filt_clr got=%b want=0", ifa.filt_clr_o);
    end
    total++;
    if (ifa.busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", ifa.busy_o);
    end
    total++;
    if (ifa.valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", ifa.valid_o);
    end
    total++;
    if (ifa.power_o !== 64'd0) begin
      bad++; $display("FAIL reset_power got=0x%h want=0", ifa.power_o);
    end
    total++;
    if (ifd.power_o !== 64'd0 || ifd.busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_d got power=0x%h busy=%b want 0/0", ifd.power_o, ifd.busy_o);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      strobe_a(rnd(), rnd());
      total++;
      if (ifa.busy_o !== 1'b0) begin
        bad++; $display("FAIL basic_busy_early strobe=%0d got=%b want=0", i, ifa.busy_o);
      end
    end
    q_a.push_back(64'd13);
    strobe_a(32'sd3, 32'sd4);
    total++;
    if (ifa.filt_clr_o !== 1'b1 || ifa.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_t1 got filt_clr=%b busy=%b want 1/1", ifa.filt_clr_o, ifa.busy_o);
    end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (ifa.filt_clr_o !== 1'b0 || ifa.valid_o !== (k == 5)) begin
        bad++;
        $display("FAIL basic_latency cyc=t+%0d got filt_clr=%b valid=%b want 0/%0d",
                 k, ifa.filt_clr_o, ifa.valid_o, (k == 5));
      end
    end
    @(negedge clk);
    total++;
    if (ifa.busy_o !== 1'b0 || ifa.power_o !== 64'd13 || q_a.size() != 0) begin
      bad++;
      $display("FAIL basic_t6 got busy=%b power=%0d pending=%0d want 0/13/0",
               ifa.busy_o, ifa.power_o, q_a.size());
    end
  endtask

  // Must start at the t+6 negedge left by test_basic.
  task automatic test_back_to_back();
    int v0;
    logic signed [31:0] a0, a1;
    v0 = vcnt_a;
    for (int i = 0; i < 4; i++) begin
      a0 = rnd();
      a1 = rnd();
      if (i == 3) q_a.push_back(model(a0, a1, 32'sd16384));
      strobe_a(a0, a1);
    end
    repeat (8) @(negedge clk);
    total++;
    if (vcnt_a != v0 + 1 || q_a.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=%0d pending=%0d", vcnt_a - v0, 1, q_a.size());
    end
  endtask

  task automatic test_clr();
    int v0;
    logic signed [31:0] a0, a1;
    v0 = vcnt_a;
    strobe_a(rnd(), rnd());
    strobe_a(rnd(), rnd());
    ifa.clr = 1'b1;
    strobe_a(rnd(), rnd());
    ifa.clr = 1'b0;
    for (int i = 0; i < 3; i++) strobe_a(rnd(), rnd());
    repeat (8) @(negedge clk);
    total++;
    if (vcnt_a != v0) begin
      bad++; $display("FAIL clr_early_valid got=%0d want=0", vcnt_a - v0);
    end
    a0 = rnd();
    a1 = rnd();
    q_a.push_back(model(a0, a1, 32'sd16384));
    strobe_a(a0, a1);
    repeat (8) @(negedge clk);
    total++;
    if (vcnt_a != v0 + 1 || q_a.size() != 0) begin
      bad++;
      $display("FAIL clr_count got=%0d want=1 pending=%0d", vcnt_a - v0, q_a.size());
    end
  endtask

  task automatic test_ignore_busy();
    int v0;
    logic signed [31:0] a0, a1;
    v0 = vcnt_a;
    for (int i = 0; i < 3; i++) strobe_a(rnd(), rnd());
    a0 = rnd();
    a1 = rnd();
    q_a.push_back(model(a0, a1, 32'sd16384));
    strobe_a(a0, a1);
    // Hold garbage strobes across SQ0..DONE; none may count or overwrite the latch.
    ifa.valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ifa.s0_i = rnd();
      ifa.s1_i = rnd();
      @(negedge clk);
    end
    ifa.valid_i = 1'b0;
    total++;
    if (vcnt_a != v0 + 1 || ifa.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL busy_first got count=%0d busy=%b want 1/0", vcnt_a - v0, ifa.busy_o);
    end
    for (int i = 0; i < 3; i++) strobe_a(rnd(), rnd());
    repeat (8) @(negedge clk);
    total++;
    if (vcnt_a != v0 + 1) begin
      bad++; $display("FAIL busy_counted got=%0d want=1", vcnt_a - v0);
    end
    a0 = rnd();
    a1 = rnd();
    q_a.push_back(model(a0, a1, 32'sd16384));
    strobe_a(a0, a1);
    repeat (8) @(negedge clk);
    total++;
    if (vcnt_a != v0 + 2 || q_a.size() != 0) begin
      bad++;
      $display("FAIL busy_second got=%0d want=2 pending=%0d", vcnt_a - v0, q_a.size());
    end
  endtask

  task automatic test_coeff();
    logic signed [31:0] b0[3], b1[3], c0[3], c1[3], d0[3], d1[3];
    logic [63:0] eb[3], ec[3], ed[3];
    int vb, vc, vd;
    b0[0] = -32'sd5; b1[0] = 32'sd2; eb[0] = 64'd49;
    c0[0] = 32'sd7;  c1[0] = 32'sd2; ec[0] = 64'd11;
    d0[0] = SMax;    d1[0] = SMax;   ed[0] = 64'h7FFF_FFFE_0000_0002;
    b0[1] = rnd();   b1[1] = rnd();  eb[1] = model(b0[1], b1[1], 32'sd32768);
    c0[1] = 32'sd1;  c1[1] = 32'sd1; ec[1] = 64'd0;
    d0[1] = SMin;    d1[1] = SMin;   ed[1] = 64'h8000_0000_0000_0000;
    b0[2] = rnd();   b1[2] = rnd();  eb[2] = model(b0[2], b1[2], 32'sd32768);
    c0[2] = SMin;    c1[2] = SMax;   ec[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    d0[2] = rnd();   d1[2] = rnd();  ed[2] = model(d0[2], d1[2], 32'sd0);
    for (int r = 0; r < 3; r++) begin
      vb = vcnt_b; vc = vcnt_c; vd = vcnt_d;
      q_b.push_back(eb[r]);
      q_c.push_back(ec[r]);
      q_d.push_back(ed[r]);
      ifb.s0_i = b0[r]; ifb.s1_i = b1[r]; ifb.valid_i = 1'b1;
      ifc.s0_i = c0[r]; ifc.s1_i = c1[r]; ifc.valid_i = 1'b1;
      ifd.s0_i = d0[r]; ifd.s1_i = d1[r]; ifd.valid_i = 1'b1;
      @(negedge clk);
      ifb.valid_i = 1'b0;
      ifc.valid_i = 1'b0;
      ifd.valid_i = 1'b0;
      repeat (7) @(negedge clk);
      total++;
      if (vcnt_b != vb + 1 || vcnt_c != vc + 1 || vcnt_d != vd + 1) begin
        bad++;
        $display("FAIL coeff_count round=%0d got b=%0d c=%0d d=%0d want 1/1/1",
                 r, vcnt_b - vb, vcnt_c - vc, vcnt_d - vd);
      end
    end
  endtask

  task automatic test_rst_scale();
    int v0;
    v0 = vcnt_a;
    for (int i = 0; i < 4; i++) strobe_a(rnd(), rnd());
    repeat (3) @(negedge clk);
    total++;
    if (ifa.busy_o !== 1'b1 || ifa.power_o === 64'd0) begin
      bad++;
      $display("FAIL rst_pre got busy=%b power=0x%h want busy=1 power!=0", ifa.busy_o, ifa.power_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (ifa.valid_o !== 1'b0 || ifa.power_o !== 64'd0 || ifa.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_scale got valid=%b power=0x%h busy=%b want 0/0/0",
               ifa.valid_o, ifa.power_o, ifa.busy_o);
    end
    repeat (6) @(negedge clk);
    total++;
    if (vcnt_a != v0) begin
      bad++; $display("FAIL rst_no_valid got=%0d want=0", vcnt_a - v0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clr();
    test_ignore_busy();
    test_coeff();
    test_rst_scale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
